// File: rtl/picorv32_native_axil_master_if.sv
// Bus bundle between the PicoRV32 native memory port and the AXI4-Lite subset bus.
// The bridge uses the master modport; the CPU/RAM side of the bench uses slave.
interface picorv32_native_axil_master_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] M_AWADDR;
    logic [2:0]  M_AWPROT;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY;
    logic        M_BVALID;
    logic        M_BREADY;
    logic [31:0] M_ARADDR;
    logic [2:0]  M_ARPROT;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_RDATA;
    logic        M_RVALID;
    logic        M_RREADY;

    modport master (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output M_AWADDR, M_AWPROT, M_AWVALID,
        input  M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID,
        input  M_WREADY,
        input  M_BVALID,
        output M_BREADY,
        output M_ARADDR, M_ARPROT, M_ARVALID,
        input  M_ARREADY,
        input  M_RDATA, M_RVALID,
        output M_RREADY
    );

    modport slave (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  M_AWADDR, M_AWPROT, M_AWVALID,
        output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID,
        output M_WREADY,
        output M_BVALID,
        input  M_BREADY,
        input  M_ARADDR, M_ARPROT, M_ARVALID,
        output M_ARREADY,
        output M_RDATA, M_RVALID,
        input  M_RREADY
    );
endinterface

// File: rtl/picorv32_native_axil_master.sv
// PicoRV32 native port to AXI4-Lite subset bridge: one transaction at a time,
// fully registered outputs, programmable wait-state timeout with sticky error.
module picorv32_native_axil_master #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
    input  logic                          aclk,
    input  logic                          areset,
    picorv32_native_axil_master_if.master bus,
    output logic                          timeout_err
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] awaddr_reg, awaddr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic        awvalid_reg, awvalid_next;
    logic        wvalid_reg, wvalid_next;
    logic        bready_reg, bready_next;
    logic [31:0] araddr_reg, araddr_next;
    logic [2:0]  arprot_reg, arprot_next;
    logic        arvalid_reg, arvalid_next;
    logic        rready_reg, rready_next;
    logic        mem_ready_reg, mem_ready_next;
    logic [31:0] mem_rdata_reg, mem_rdata_next;
    logic        timeout_err_reg, timeout_err_next;

    logic wait_state, timeout_hit, aw_ok, w_ok, wr_both;

    // A channel counts as done once its VALID is low, or it handshakes on this edge.
    always_comb begin
        wait_state  = (state_reg == WR_AW_W) || (state_reg == WR_B) ||
                      (state_reg == RD_AR) || (state_reg == RD_R);
        timeout_hit = TIMEOUT_EN && wait_state && (cnt_reg == TIMEOUT_LAST);
        aw_ok       = !awvalid_reg || bus.M_AWREADY;
        w_ok        = !wvalid_reg || bus.M_WREADY;
        wr_both     = aw_ok && w_ok;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Awaited events are tested before the timeout so they win a tie.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.mem_valid) begin
                    state_next = (bus.mem_wstrb != 4'd0) ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (wr_both)          state_next = WR_B;
                else if (timeout_hit) state_next = RESP;
            end
            WR_B: begin
                if (bus.M_BVALID || timeout_hit) state_next = RESP;
            end
            RD_AR: begin
                if (bus.M_ARREADY)    state_next = RD_R;
                else if (timeout_hit) state_next = RESP;
            end
            RD_R: begin
                if (bus.M_RVALID || timeout_hit) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next         = cnt_reg;
        awaddr_next      = awaddr_reg;
        wdata_next       = wdata_reg;
        wstrb_next       = wstrb_reg;
        awvalid_next     = awvalid_reg;
        wvalid_next      = wvalid_reg;
        bready_next      = bready_reg;
        araddr_next      = araddr_reg;
        arprot_next      = arprot_reg;
        arvalid_next     = arvalid_reg;
        rready_next      = rready_reg;
        mem_ready_next   = 1'b0;
        mem_rdata_next   = mem_rdata_reg;
        timeout_err_next = timeout_err_reg;

        if (state_reg == IDLE) begin
            cnt_next = 32'd0;
        end else if (wait_state) begin
            cnt_next = cnt_reg + 32'd1;
        end

        case (state_reg)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (bus.mem_wstrb != 4'd0) begin
                        awaddr_next  = {bus.mem_addr[31:2], 2'b00};
                        wdata_next   = bus.mem_wdata;
                        wstrb_next   = bus.mem_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        araddr_next  = {bus.mem_addr[31:2], 2'b00};
                        arprot_next  = bus.mem_instr ? 3'b100 : 3'b000;
                        arvalid_next = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                awvalid_next = awvalid_reg && !bus.M_AWREADY;
                wvalid_next  = wvalid_reg && !bus.M_WREADY;
                if (wr_both) begin
                    bready_next = 1'b1;
                end else if (timeout_hit) begin
                    awvalid_next     = 1'b0;
                    wvalid_next      = 1'b0;
                    mem_ready_next   = 1'b1;
                    timeout_err_next = 1'b1;
                end
            end
            WR_B: begin
                if (bus.M_BVALID) begin
                    bready_next    = 1'b0;
                    mem_ready_next = 1'b1;
                end else if (timeout_hit) begin
                    bready_next      = 1'b0;
                    mem_ready_next   = 1'b1;
                    timeout_err_next = 1'b1;
                end
            end
            RD_AR: begin
                if (bus.M_ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                end else if (timeout_hit) begin
                    arvalid_next     = 1'b0;
                    mem_ready_next   = 1'b1;
                    mem_rdata_next   = TIMEOUT_RDATA;
                    timeout_err_next = 1'b1;
                end
            end
            RD_R: begin
                if (bus.M_RVALID) begin
                    rready_next    = 1'b0;
                    mem_ready_next = 1'b1;
                    mem_rdata_next = bus.M_RDATA;
                end else if (timeout_hit) begin
                    rready_next      = 1'b0;
                    mem_ready_next   = 1'b1;
                    mem_rdata_next   = TIMEOUT_RDATA;
                    timeout_err_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_reg         <= 32'd0;
            awaddr_reg      <= 32'd0;
            wdata_reg       <= 32'd0;
            wstrb_reg       <= 4'd0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            araddr_reg      <= 32'd0;
            arprot_reg      <= 3'd0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            mem_ready_reg   <= 1'b0;
            mem_rdata_reg   <= 32'd0;
            timeout_err_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            awaddr_reg      <= awaddr_next;
            wdata_reg       <= wdata_next;
            wstrb_reg       <= wstrb_next;
            awvalid_reg     <= awvalid_next;
            wvalid_reg      <= wvalid_next;
            bready_reg      <= bready_next;
            araddr_reg      <= araddr_next;
            arprot_reg      <= arprot_next;
            arvalid_reg     <= arvalid_next;
            rready_reg      <= rready_next;
            mem_ready_reg   <= mem_ready_next;
            mem_rdata_reg   <= mem_rdata_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign bus.mem_ready = mem_ready_reg;
    assign bus.mem_rdata = mem_rdata_reg;
    assign bus.M_AWADDR  = awaddr_reg;
    assign bus.M_AWPROT  = 3'b000;
    assign bus.M_AWVALID = awvalid_reg;
    assign bus.M_WDATA   = wdata_reg;
    assign bus.M_WSTRB   = wstrb_reg;
    assign bus.M_WVALID  = wvalid_reg;
    assign bus.M_BREADY  = bready_reg;
    assign bus.M_ARADDR  = araddr_reg;
    assign bus.M_ARPROT  = arprot_reg;
    assign bus.M_ARVALID = arvalid_reg;
    assign bus.M_RREADY  = rready_reg;
    assign timeout_err   = timeout_err_reg;
endmodule

// File: doc/picorv32_native_axil_master.md
Name: picorv32_native_axil_master

Overview:
Bridge between the PicoRV32 native memory port (mem_valid/mem_ready) and the AXI4-Lite "subset" bus (no BRESP/RRESP) used by the RAM slave. It sits directly upstream of the RAM slave and converts each native request into one AXI4-Lite read or write transaction. It runs one transaction at a time and has a programmable response timeout with a sticky error flag.

Parameters:
TIMEOUT_CYCLES, 1024, cycles to wait in any AXI wait state before aborting; 0 disables the timeout
TIMEOUT_RDATA, 32'hFFFF_FFFF, value returned on mem_rdata for an aborted read

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
mem_valid  in  1  CPU request valid
mem_instr  in  1  request is an instruction fetch
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 = read, nonzero = write
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
M_AWADDR  out  32  write address
M_AWPROT  out  3  write protection, constant 3'b000
M_AWVALID  out  1  write address valid
M_AWREADY  in  1  write address ready
M_WDATA  out  32  write data
M_WSTRB  out  4  write strobes
M_WVALID  out  1  write data valid
M_WREADY  in  1  write data ready
M_BVALID  in  1  write response valid
M_BREADY  out  1  write response ready
M_ARADDR  out  32  read address
M_ARPROT  out  3  3'b100 if mem_instr, else 3'b000
M_ARVALID  out  1  read address valid
M_ARREADY  in  1  read address ready
M_RDATA  in  32  read data
M_RVALID  in  1  read data valid
M_RREADY  out  1  read data ready
timeout_err  out  1  sticky; set on any abort, cleared only by reset

Behaviour:
- All outputs are registered. On reset, every VALID/READY output, mem_ready and timeout_err = 0; mem_rdata = 0; addresses, data and strobes = 0; state = IDLE; timeout counter = 0.
- Reset applied mid-transaction drops all VALIDs at that same edge. There is no completion and no mem_ready.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE: if mem_valid=1 at a clock edge, latch the request. AXI addresses = {mem_addr[31:2], 2'b00}.
  - mem_wstrb != 0: assert AWVALID and WVALID together; go to WR_AW_W.
  - mem_wstrb == 0: assert ARVALID; go to RD_AR.
- WR_AW_W: AWVALID and WVALID each deassert on their own handshake (VALID & READY at an edge). AW and W may complete in either order or in the same cycle. When both have completed, assert BREADY and go to WR_B.
- WR_B: at the edge where BVALID=1, deassert BREADY, set mem_ready=1, go to RESP.
- RD_AR: on the AR handshake, deassert ARVALID, assert RREADY, go to RD_R.
- RD_R: at the edge where RVALID=1, capture RDATA into mem_rdata, deassert RREADY, set mem_ready=1, go to RESP.
- RESP: mem_ready=1 for exactly this one cycle; the next edge clears it and returns to IDLE. IDLE never samples mem_valid during the mem_ready cycle, so it never re-launches a stale request.
- VALID stability: once asserted, a VALID stays high with stable payload until its handshake. Latched payload ignores later changes on the mem_* inputs.
- Timeout counter: cleared on leaving IDLE; increments every cycle spent in WR_AW_W, WR_B, RD_AR or RD_R.
- Timeout abort: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without the awaited event:
  - drop all VALID/READY outputs;
  - set timeout_err;
  - mem_rdata = TIMEOUT_RDATA for reads (unchanged for writes);
  - go to RESP, so mem_ready still pulses.
- An awaited event on the same edge as the timeout wins; the transaction completes normally.
- Minimum latency with an always-ready, 1-cycle-response slave: mem_valid sampled at edge N → ARVALID high in cycle N+1 → RVALID high in cycle N+2 → mem_ready high in cycle N+3. Writes have the same latency.

Test Plan:
- Read: preload RAM word 0x10 = 0xCAFEBABE; mem_valid=1, addr=0x40, wstrb=0 → exactly one AR handshake with ARADDR=0x40, ARPROT=000; mem_ready pulses once, 3 cycles after acceptance, with rdata=0xCAFEBABE.
- Write, partial strobe: addr=0x44, wdata=0x11223344, wstrb=4'b0110 → one AW and one W handshake; mem_ready pulses 3 cycles after acceptance; a later read of 0x44 over original 0xAABBCCDD returns 0xAA2233DD.
- Split AW/W: bench delays AWREADY 3 cycles and holds WREADY high → WVALID drops after 1 cycle; AWVALID held with stable AWADDR until its handshake; BREADY asserts only after both handshakes; exactly one mem_ready.
- Fetch protection and alignment: mem_instr=1, addr=0x0000_0103 → ARPROT=3'b100, ARADDR=0x0000_0100.
- Timeout: TIMEOUT_CYCLES=16, RVALID never asserted → mem_ready pulses with rdata=0xFFFFFFFF, timeout_err=1 and stays 1 through following good transactions until areset.
- Reset mid-write: assert areset while AWVALID=1 → at that edge AWVALID=WVALID=BREADY=mem_ready=0; after release, a new read completes normally.
